// File: rtl/sum_accumulator.sv
// ============================================================================
//  Module   : sum_accumulator
//  Summary  : Sums FRAME_LEN adder sum words per frame behind a valid/ready
//             input. Each frame total is presented on a registered
//             valid/ready output, together with a sticky overflow flag.
//  Options  : SUM_ACC_SATURATE_EN clamps the total to all-ones on carry-out.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sum_accumulator #(
    parameter int N         = 2,
    parameter int FRAME_LEN = 4,
    parameter int ACC_W     = N + 9
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [N:0]                     in_sum,
    input  logic                           clear,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [ACC_W-1:0]               out_acc,
    output logic                           out_overflow,
    output logic [$clog2(FRAME_LEN+1)-1:0] frame_cnt
);

    localparam int c_CNT_W = $clog2(FRAME_LEN + 1);
    localparam int c_PAD_W = ACC_W - N;
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(FRAME_LEN - 1);

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    state_t             r_state;
    logic [ACC_W-1:0]   r_acc;
    logic               r_ovf;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_out_valid;
    logic [ACC_W-1:0]   r_out_acc;
    logic               r_out_ovf;

    logic               w_in_ready;
    logic               w_accept;
    logic               w_last;
    logic [ACC_W:0]     w_in_ext;
    logic [ACC_W:0]     w_add;
    logic               w_carry;
    logic [ACC_W-1:0]   w_acc_next;
    logic               w_ovf_next;

    // in_ready depends on state only, so it never combinationally follows in_valid.
    assign w_in_ready = (r_state == ST_ACCUM);
    assign w_accept   = in_valid & w_in_ready;
    assign w_last     = (r_cnt == c_CNT_LAST);

    assign w_in_ext   = {{c_PAD_W{1'b0}}, in_sum};
    assign w_add      = {1'b0, r_acc} + w_in_ext;
    assign w_carry    = w_add[ACC_W];
    assign w_ovf_next = r_ovf | w_carry;

`ifdef SUM_ACC_SATURATE_EN
    // Once clamped, any further carry re-clamps, so the total stays at all-ones.
    assign w_acc_next = w_carry ? {ACC_W{1'b1}} : w_add[ACC_W-1:0];
`else
    assign w_acc_next = w_add[ACC_W-1:0];
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_ACCUM;
            r_acc       <= '0;
            r_ovf       <= 1'b0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_acc   <= '0;
            r_out_ovf   <= 1'b0;
        end else if (clear) begin
            // Abort: any sample presented this cycle is dropped; out_acc keeps its value.
            r_state     <= ST_ACCUM;
            r_acc       <= '0;
            r_ovf       <= 1'b0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_ACCUM: begin
                    if (w_accept) begin
                        r_acc <= w_acc_next;
                        r_ovf <= w_ovf_next;
                        r_cnt <= r_cnt + c_CNT_ONE;
                        if (w_last) begin
                            r_out_acc   <= w_acc_next;
                            r_out_ovf   <= w_ovf_next;
                            r_out_valid <= 1'b1;
                            r_state     <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (r_out_valid && out_ready) begin
                        r_out_valid <= 1'b0;
                        r_acc       <= '0;
                        r_ovf       <= 1'b0;
                        r_cnt       <= '0;
                        r_state     <= ST_ACCUM;
                    end
                end
                default: begin
                    r_state <= ST_ACCUM;
                end
            endcase
        end
    end

    assign in_ready     = w_in_ready;
    assign out_valid    = r_out_valid;
    assign out_acc      = r_out_acc;
    assign out_overflow = r_out_ovf;
    assign frame_cnt    = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_sum_accumulator.sv
// ============================================================================
//  Module   : tb_sum_accumulator
//  Summary  : Directed self-checking bench for sum_accumulator (three configs).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sum_accumulator;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // a: N=2 FRAME_LEN=4 ACC_W=11
    logic        a_in_valid, a_in_ready, a_clear, a_out_valid, a_out_ready, a_out_ovf;
    logic [2:0]  a_in_sum;
    logic [10:0] a_out_acc;
    logic [2:0]  a_cnt;
    // b: N=2 FRAME_LEN=4 ACC_W=4
    logic        b_in_valid, b_in_ready, b_clear, b_out_valid, b_out_ready, b_out_ovf;
    logic [2:0]  b_in_sum;
    logic [3:0]  b_out_acc;
    logic [2:0]  b_cnt;
    // c: N=2 FRAME_LEN=1 ACC_W=11
    logic        c_in_valid, c_in_ready, c_clear, c_out_valid, c_out_ready, c_out_ovf;
    logic [2:0]  c_in_sum;
    logic [10:0] c_out_acc;
    logic [0:0]  c_cnt;

    sum_accumulator #(.N(2), .FRAME_LEN(4), .ACC_W(11)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_sum(a_in_sum), .clear(a_clear), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .out_acc(a_out_acc), .out_overflow(a_out_ovf),
        .frame_cnt(a_cnt)
    );

    sum_accumulator #(.N(2), .FRAME_LEN(4), .ACC_W(4)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_sum(b_in_sum), .clear(b_clear), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_acc(b_out_acc), .out_overflow(b_out_ovf),
        .frame_cnt(b_cnt)
    );

    sum_accumulator #(.N(2), .FRAME_LEN(1), .ACC_W(11)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_sum(c_in_sum), .clear(c_clear), .out_valid(c_out_valid),
        .out_ready(c_out_ready), .out_acc(c_out_acc), .out_overflow(c_out_ovf),
        .frame_cnt(c_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Present one sample to config a and advance one clock.
    task automatic a_push(input logic [2:0] s);
        a_in_valid = 1'b1;
        a_in_sum   = s;
        tick();
        a_in_valid = 1'b0;
    endtask

    task automatic b_push(input logic [2:0] s);
        b_in_valid = 1'b1;
        b_in_sum   = s;
        tick();
        b_in_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        a_in_valid = 0; a_in_sum = 0; a_clear = 0; a_out_ready = 0;
        b_in_valid = 0; b_in_sum = 0; b_clear = 0; b_out_ready = 0;
        c_in_valid = 0; c_in_sum = 0; c_clear = 0; c_out_ready = 0;
        tick();
        tick();
        chk("rst_a_valid", 32'(a_out_valid), 0);
        chk("rst_a_acc",   32'(a_out_acc),   0);
        chk("rst_a_ovf",   32'(a_out_ovf),   0);
        chk("rst_a_cnt",   32'(a_cnt),       0);
        chk("rst_c_valid", 32'(c_out_valid), 0);
        rst_n = 1'b1;
        tick();
        chk("rst_a_ready", 32'(a_in_ready), 1);
        chk("rst_b_ready", 32'(b_in_ready), 1);

        // Basic frame, in_valid held high.
        a_in_valid = 1'b1;
        a_in_sum = 3; tick();
        chk("basic_cnt1", 32'(a_cnt), 1);
        a_in_sum = 5; tick();
        a_in_sum = 7; tick();
        chk("basic_cnt3", 32'(a_cnt), 3);
        chk("basic_novalid", 32'(a_out_valid), 0);
        a_in_sum = 1; tick();
        a_in_valid = 1'b0;
        chk("basic_valid", 32'(a_out_valid), 1);
        chk("basic_acc",   32'(a_out_acc),   16);
        chk("basic_ovf",   32'(a_out_ovf),   0);
        chk("basic_ready", 32'(a_in_ready),  0);
        a_out_ready = 1'b1;
        tick();
        a_out_ready = 1'b0;
        chk("basic_hs_valid", 32'(a_out_valid), 0);
        chk("basic_hs_ready", 32'(a_in_ready),  1);
        chk("basic_hs_cnt",   32'(a_cnt),       0);

        // Gaps on the input, then backpressure on the output.
        a_push(3); tick();
        chk("gap_cnt_hold", 32'(a_cnt), 1);
        a_push(5); tick();
        a_push(7); tick();
        a_push(1);
        chk("gap_valid", 32'(a_out_valid), 1);
        a_in_valid = 1'b1;
        a_in_sum   = 2;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_acc",   32'(a_out_acc),   16);
            chk("bp_valid", 32'(a_out_valid), 1);
            chk("bp_ready", 32'(a_in_ready),  0);
        end
        a_out_ready = 1'b1;
        tick();
        a_out_ready = 1'b0;
        a_in_valid  = 1'b0;
        chk("bp_hs_valid", 32'(a_out_valid), 0);
        chk("bp_hs_ready", 32'(a_in_ready),  1);
        chk("bp_hs_cnt",   32'(a_cnt),       0);

        // Clear mid-frame drops the concurrent sample.
        a_push(6);
        a_push(6);
        chk("clr_cnt2", 32'(a_cnt), 2);
        a_clear = 1'b1;
        a_push(7);
        a_clear = 1'b0;
        chk("clr_cnt0", 32'(a_cnt), 0);
        a_push(1); a_push(2); a_push(3); a_push(4);
        chk("clr_valid", 32'(a_out_valid), 1);
        chk("clr_acc",   32'(a_out_acc),   10);
        a_out_ready = 1'b1;
        tick();
        a_out_ready = 1'b0;

        // Clear while holding a result.
        a_push(1); a_push(1); a_push(1); a_push(1);
        chk("hclr_pre_valid", 32'(a_out_valid), 1);
        a_clear = 1'b1;
        tick();
        a_clear = 1'b0;
        chk("hclr_valid", 32'(a_out_valid), 0);
        chk("hclr_ready", 32'(a_in_ready),  1);
        chk("hclr_cnt",   32'(a_cnt),       0);
        a_push(2); a_push(2); a_push(2); a_push(2);
        chk("hclr_next_acc", 32'(a_out_acc), 8);

        // Reset while holding a result.
        rst_n = 1'b0;
        tick();
        chk("hrst_valid", 32'(a_out_valid), 0);
        chk("hrst_acc",   32'(a_out_acc),   0);
        chk("hrst_ovf",   32'(a_out_ovf),   0);
        chk("hrst_cnt",   32'(a_cnt),       0);
        rst_n = 1'b1;
        tick();
        chk("hrst_ready", 32'(a_in_ready), 1);

        // Overflow with a 4-bit accumulator: 7*4 = 28.
        b_push(7); b_push(7); b_push(7); b_push(7);
        chk("ovf_valid", 32'(b_out_valid), 1);
`ifdef SUM_ACC_SATURATE_EN
        chk("ovf_acc", 32'(b_out_acc), 15);
`else
        chk("ovf_acc", 32'(b_out_acc), 12);
`endif
        chk("ovf_flag", 32'(b_out_ovf), 1);
        b_out_ready = 1'b1;
        tick();
        b_out_ready = 1'b0;
        b_push(1); b_push(1); b_push(1); b_push(1);
        chk("ovf_next_acc",  32'(b_out_acc), 4);
        chk("ovf_next_flag", 32'(b_out_ovf), 0);

        // FRAME_LEN=1: each sample is a frame, one result every two cycles.
        c_in_valid = 1'b1;
        c_in_sum   = 5;
        tick();
        chk("f1_valid", 32'(c_out_valid), 1);
        chk("f1_acc",   32'(c_out_acc),   5);
        chk("f1_ready", 32'(c_in_ready),  0);
        c_out_ready = 1'b1;
        c_in_sum    = 6;
        tick();
        chk("f1_hs_valid", 32'(c_out_valid), 0);
        chk("f1_hs_ready", 32'(c_in_ready),  1);
        tick();
        chk("f1_b2b_valid", 32'(c_out_valid), 1);
        chk("f1_b2b_acc",   32'(c_out_acc),   6);
        c_in_sum = 3;
        tick();
        chk("f1_b2b_gap", 32'(c_out_valid), 0);
        tick();
        chk("f1_b2b_acc2", 32'(c_out_acc), 3);
        chk("f1_b2b_ovf",  32'(c_out_ovf), 0);
        c_in_valid  = 1'b0;
        c_out_ready = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
